// File: rtl/tile_game_core.sv
// tile_game_core: falling-tile playfield, key judging and saturating score
// for the piano-tiles game. The VGA drawing logic reads rows and the event pulses.
module tile_game_core #(
  parameter int          LANES        = 4,
  parameter int          ROWS         = 7,
  parameter int          SCORE_W      = 16,
  parameter int          TICK_W       = 24,
  parameter int          SPEEDUP_HITS = 10,
  parameter int          MIN_PERIOD   = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LANES-1:0]        key,
  input  logic                    strict,
  input  logic [TICK_W-1:0]       tick_period,
  output logic [ROWS*LANES-1:0]   rows,
  output logic [SCORE_W-1:0]      score,
  output logic [1:0]              state,
  output logic                    shift,
  output logic                    hit,
  output logic                    miss,
  output logic                    wrong,
  output logic [LANES-1:0]        fail_lane
);

  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int HC_W    = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;
  localparam int HC_LAST = (SPEEDUP_HITS > 0) ? SPEEDUP_HITS - 1 : 0;
  localparam logic [TICK_W-1:0] MIN_P = TICK_W'(MIN_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  state_t            st;
  logic [LANES-1:0]  key_q;
  logic [15:0]       lfsr;
  logic [TICK_W-1:0] cnt;
  logic [TICK_W-1:0] cur_period;
  logic [TICK_W-1:0] period_next;
  logic [HC_W-1:0]   hit_cnt;

  logic [LANES-1:0]   kedge;
  logic [LANES-1:0]   bottom;
  logic [LANES-1:0]   spawn;
  logic               is_hit;
  logic               is_wrong;
  logic               expire;
  logic               speed_step;
  logic [15:0]        lfsr_next;
  logic [SCORE_W-1:0] score_inc;
  logic [TICK_W-1:0]  period_dec;
  logic [TICK_W-1:0]  period_sped;
  logic [TICK_W-1:0]  start_period;

  assign state = st;

  // Judge the current key edge, detect tick expiry and precompute the next period/LFSR/score values
  always_comb begin
    kedge        = key & ~key_q;
    bottom       = rows[(ROWS-1)*LANES +: LANES];
    is_hit       = (st == ST_RUN) && (kedge != '0) && (bottom != '0) && (kedge == bottom);
    is_wrong     = (st == ST_RUN) && (kedge != '0) && (bottom != '0) && (kedge != bottom) && strict;
    expire       = (st == ST_RUN) && (cnt == cur_period - TICK_W'(1));
    spawn        = '0;
    spawn[lfsr[LW-1:0]] = 1'b1;
    lfsr_next    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    score_inc    = (score == '1) ? score : score + 1'b1;
    period_dec   = period_next - (period_next >> 3);
    if (period_dec >= MIN_P)
      period_sped = period_dec;
    else if (period_next < MIN_P)
      period_sped = period_next;
    else
      period_sped = MIN_P;
    speed_step   = is_hit && (SPEEDUP_HITS != 0) && (hit_cnt == HC_W'(HC_LAST));
    start_period = (tick_period == '0) ? TICK_W'(1) : tick_period;
  end

  // Game FSM: start/restart, tick shifting, press judging, speed-up and registered event pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= ST_IDLE;
      key_q       <= '1;
      lfsr        <= LFSR_SEED;
      cnt         <= '0;
      cur_period  <= TICK_W'(1);
      period_next <= TICK_W'(1);
      hit_cnt     <= '0;
      rows        <= '0;
      score       <= '0;
      fail_lane   <= '0;
      shift       <= 1'b0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      wrong       <= 1'b0;
    end else begin
      key_q <= key;
      shift <= 1'b0;
      hit   <= 1'b0;
      miss  <= 1'b0;
      wrong <= 1'b0;
      case (st)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            rows        <= '0;
            score       <= '0;
            fail_lane   <= '0;
            cnt         <= '0;
            cur_period  <= start_period;
            period_next <= start_period;
            hit_cnt     <= '0;
            st          <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (is_wrong) begin
            wrong     <= 1'b1;
            fail_lane <= kedge;
            st        <= ST_OVER;
          end else begin
            if (is_hit) begin
              hit   <= 1'b1;
              score <= score_inc;
              rows[(ROWS-1)*LANES +: LANES] <= '0;
              if (speed_step) begin
                hit_cnt     <= '0;
                period_next <= period_sped;
              end else begin
                hit_cnt <= hit_cnt + 1'b1;
              end
            end
            if (expire) begin
              cnt        <= '0;
              cur_period <= speed_step ? period_sped : period_next;
              if ((bottom != '0) && !is_hit) begin
                miss      <= 1'b1;
                fail_lane <= bottom;
                st        <= ST_OVER;
              end else begin
                shift <= 1'b1;
                rows  <= {rows[(ROWS-1)*LANES-1:0], spawn};
                lfsr  <= lfsr_next;
              end
            end else begin
              cnt <= cnt + TICK_W'(1);
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
